// File: rtl/slice_collector.sv
// ----------------------------------------------------------------------------
// slice_collector
//
// Collects a block of DEPTH slices, each WIDTH bits wide, from a permutation
// output stream. It transposes them into WIDTH lanes of DEPTH bits and then
// presents the lanes one at a time through a valid/ready handshake.
//
// Slice k of the block is stored as bit k of every lane. Once DEPTH slices
// have been accepted, the lanes are drained in order 0..WIDTH-1. A one-cycle
// done pulse follows the transfer of the last lane.
//
// Parameters
//   WIDTH      slice width and number of lanes (lane_idx is 5 bits, so <= 32)
//   DEPTH      slices per block and lane width
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start        one-cycle pulse: clear buffer, (re)enter FILL
//   in           incoming slice
//   in_valid     in is valid this cycle
//   ready        block can accept a slice (FILL only)
//   lane_out     currently presented lane (0 outside DRAIN)
//   lane_idx     index of lane_out (0 outside DRAIN)
//   out_valid    lane_out/lane_idx valid (DRAIN only)
//   out_ready    consumer accepts the presented lane
//   done         one-cycle pulse after the last lane transfers
//   lane_parity  XOR-reduce of lane_out while out_valid, else 0
//
// Build option
//   SLICE_COLLECTOR_PARITY_EN  when defined, builds the lane parity tree;
//                              otherwise lane_parity is tied low.
//
// States
//   state   | meaning
//   --------+---------------------------------------------------------
//   S_IDLE  | waiting for start; no handshakes active
//   S_FILL  | accepting slices, cnt_q counts slices accepted so far
//   S_DRAIN | presenting lane idx_q; advance on out_ready
// ----------------------------------------------------------------------------
module slice_collector #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    output logic             ready,
    output logic [DEPTH-1:0] lane_out,
    output logic [4:0]       lane_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             done,
    output logic             lane_parity
);

    localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);
    localparam logic [4:0]       LAST_IDX = 5'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       idx_q, idx_d;
    logic             done_q, done_d;
    logic [DEPTH-1:0] lane_q [WIDTH];
    logic [DEPTH-1:0] lane_d [WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                lane_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            for (int i = 0; i < WIDTH; i++) begin
                lane_q[i] <= lane_d[i];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        done_d    = 1'b0;
        ready     = 1'b0;
        out_valid = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            lane_d[i] = lane_q[i];
        end

        case (state_q)
            S_FILL: begin
                ready = 1'b1;
                if (!start && in_valid) begin
                    for (int i = 0; i < WIDTH; i++) begin
                        lane_d[i][cnt_q] = in[i];
                    end
                    // Counter resets on exit rather than wrapping.
                    if (cnt_q == LAST_CNT) begin
                        cnt_d   = '0;
                        state_d = S_DRAIN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                out_valid = 1'b1;
                if (!start && out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // start has priority over any slice or lane handshake in every state.
        if (start) begin
            for (int i = 0; i < WIDTH; i++) begin
                lane_d[i] = '0;
            end
            cnt_d   = '0;
            idx_d   = '0;
            done_d  = 1'b0;
            state_d = S_FILL;
        end
    end

    assign lane_idx = idx_q;
    assign done     = done_q;
    assign lane_out = (state_q == S_DRAIN && idx_q <= LAST_IDX) ? lane_q[idx_q] : '0;

`ifdef SLICE_COLLECTOR_PARITY_EN
    // lane_out is already 0 outside DRAIN; the gate keeps the definition explicit.
    assign lane_parity = out_valid & (^lane_out);
`else
    assign lane_parity = 1'b0;
`endif

endmodule
